// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code parser + show-ahead key FIFO: strips break sequences, tags E0 keys.
// Optional typematic repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_received_data,
  input  logic             ps2_received_data_strb,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_overflow
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_BREAK     = 2'd1;
  localparam logic [1:0] S_EXT       = 2'd2;
  localparam logic [1:0] S_EXT_BREAK = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [8:0]       head_q, head_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [8:0]       mem_q [DEPTH];

  logic             make_vld, make_ext, push_req, do_push, pop, full, is_drop;
  logic [8:0]       new_entry;

  // Status/ack bytes that never represent a key
  always_comb begin
    is_drop = 1'b0;
    case (ps2_received_data)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: is_drop = 1'b1;
      default:                                 is_drop = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    make_vld = 1'b0;
    make_ext = 1'b0;
    if (ps2_received_data_strb) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_received_data == 8'hF0)      state_d = S_BREAK;
          else if (ps2_received_data == 8'hE0) state_d = S_EXT;
          else if (!is_drop)                   make_vld = 1'b1;
        end
        S_EXT: begin
          if (ps2_received_data == 8'hF0)      state_d = S_EXT_BREAK;
          else if (ps2_received_data == 8'hE0) state_d = S_EXT;
          else begin
            state_d  = S_IDLE;
            make_vld = !is_drop;
            make_ext = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign new_entry = {make_ext, ps2_received_data};

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_vld_q, held_vld_d;
  logic [8:0] held_q, held_d;
  logic       brk_vld, brk_ext;

  // Held-key tracking suppresses auto-repeat makes until that key's break arrives
  always_comb begin
    brk_vld    = ps2_received_data_strb && (state_q == S_BREAK || state_q == S_EXT_BREAK);
    brk_ext    = (state_q == S_EXT_BREAK);
    push_req   = make_vld && !(held_vld_q && held_q == new_entry);
    held_vld_d = held_vld_q;
    held_d     = held_q;
    if (push_req) begin
      held_vld_d = 1'b1;
      held_d     = new_entry;
    end else if (brk_vld && held_vld_q && held_q == {brk_ext, ps2_received_data}) begin
      held_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_vld_q <= 1'b0;
      held_q     <= 9'h000;
    end else begin
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
    end
  end
`else
  assign push_req = make_vld;
`endif

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = (count_q != '0) && key_ready;
    do_push  = push_req && (!full || pop);
    ovf_d    = push_req && full && !pop;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    // Next head is the entry being written this cycle when it lands at the new read pointer
    if (count_d != '0) begin
      if (do_push && wr_ptr_q == rd_ptr_d) head_d = new_entry;
      else                                 head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 9'h000;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign key_code      = head_q[7:0];
  assign key_ext       = head_q[8];
  assign key_valid     = valid_q;
  assign fifo_count    = count_q;
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH=8).
module tb_ps2_key_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] fifo_count;
  logic       fifo_overflow;

  int errors = 0;
  int checks = 0;
  int ovf_cnt = 0;
  logic [8:0] popq [$];

  ps2_key_fifo #(.DEPTH(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .key_code               (key_code),
    .key_ext                (key_ext),
    .key_valid              (key_valid),
    .key_ready              (key_ready),
    .fifo_count             (fifo_count),
    .fifo_overflow          (fifo_overflow)
  );

  always #10 clk = ~clk;

  // Records every accepted head entry and every overflow pulse, sampled before the edge updates
  always @(posedge clk) begin
    if (key_valid && key_ready) popq.push_back({key_ext, key_code});
    if (fifo_overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe; consecutive calls produce back-to-back strobes
  task automatic send(input logic [7:0] b);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    @(posedge clk);
    #1;
    ps2_received_data_strb = 1'b0;
  endtask

  task automatic drain(input int n);
    key_ready = 1'b1;
    step(n);
    key_ready = 1'b0;
  endtask

  logic [7:0] codes [10];
  logic [7:0] exp_codes [9];

  initial begin
    codes     = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h23, 8'h24};
    exp_codes = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h21, 8'h22, 8'h24};
    rst = 1'b0;
    ps2_received_data = 8'h00;
    ps2_received_data_strb = 1'b0;
    key_ready = 1'b0;
    step(2);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_ext", 32'(key_ext), 0);
    check("rst_ovf", 32'(fifo_overflow), 0);
    rst = 1'b1;
    step(1);

    // Ready on an empty FIFO must not underflow
    drain(2);
    check("empty_ready_count", 32'(fifo_count), 0);

    // Buffered makes with no consumer
    send(8'h1C);
    check("t1_valid_latency", 32'(key_valid), 1);
    check("t1_head_first", 32'(key_code), 32'h1C);
    send(8'h29);
    send(8'h32);
    check("t1_count", 32'(fifo_count), 3);
    check("t1_head_code", 32'(key_code), 32'h1C);
    check("t1_head_ext", 32'(key_ext), 0);
    popq.delete();
    drain(4);
    check("t1_pop_n", popq.size(), 3);
    check("t1_pop0", 32'(popq[0]), 32'h01C);
    check("t1_pop1", 32'(popq[1]), 32'h029);
    check("t1_pop2", 32'(popq[2]), 32'h032);
    check("t1_empty_valid", 32'(key_valid), 0);
    check("t1_hold_code", 32'(key_code), 32'h32);

    // Break stripping with a live consumer
    popq.delete();
    key_ready = 1'b1;
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h21);
    step(3);
    key_ready = 1'b0;
    check("t2_pop_n", popq.size(), 2);
    check("t2_pop0", 32'(popq[0]), 32'h01C);
    check("t2_pop1", 32'(popq[1]), 32'h021);

    // Extended make/break, dropped status byte
    popq.delete();
    key_ready = 1'b1;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hFA); send(8'h5A);
    step(3);
    key_ready = 1'b0;
    check("t3_pop_n", popq.size(), 2);
    check("t3_pop0", 32'(popq[0]), 32'h175);
    check("t3_pop1", 32'(popq[1]), 32'h05A);
    check("t3_count", 32'(fifo_count), 0);

    // Overflow on the ninth make, then push+pop while full
    ovf_cnt = 0;
    for (int i = 0; i < 8; i++) send(codes[i]);
    check("t4_count_full", 32'(fifo_count), 8);
    check("t4_no_ovf_yet", 32'(fifo_overflow), 0);
    send(codes[8]);
    check("t4_ovf_pulse", 32'(fifo_overflow), 1);
    check("t4_count_still", 32'(fifo_count), 8);
    step(1);
    check("t4_ovf_cleared", 32'(fifo_overflow), 0);
    check("t4_ovf_once", ovf_cnt, 1);
    popq.delete();
    key_ready = 1'b1;
    send(codes[9]);
    key_ready = 1'b0;
    check("t4_full_pushpop_count", 32'(fifo_count), 8);
    check("t4_full_pushpop_ovf", 32'(fifo_overflow), 0);
    drain(10);
    check("t4_pop_n", popq.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("t4_pop%0d", i), 32'(popq[i]), 32'(exp_codes[i]));
    check("t4_ovf_total", ovf_cnt, 1);

    // Typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t5_repeat_count", 32'(fifo_count), 1);
`else
    check("t5_repeat_count", 32'(fifo_count), 3);
`endif
    drain(4);
    send(8'hF0); send(8'h1C); send(8'h1C);
    check("t5_after_break", 32'(fifo_count), 1);
    drain(2);

    // Async reset mid break sequence
    send(8'h15); send(8'h16); send(8'h1A); send(8'hE0); send(8'hF0);
    check("t6_pre_count", 32'(fifo_count), 3);
    #3 rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(key_valid), 0);
    check("t6_async_count", 32'(fifo_count), 0);
    step(2);
    rst = 1'b1;
    step(1);
    send(8'h1C);
    check("t6_fresh_count", 32'(fifo_count), 1);
    check("t6_fresh_code", 32'(key_code), 32'h1C);
    check("t6_fresh_ext", 32'(key_ext), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Sits between ps2_controller and morse_code_encoder.
- Consumes raw PS/2 scan-code bytes (ps2_received_data / ps2_received_data_strb) and strips break sequences (F0 xx, E0 F0 xx).
- Tags extended keys (E0 prefix) and buffers the resulting make codes in a small show-ahead FIFO with a valid/ready handshake.
- Keys arriving while the Morse encoder is busy sending are therefore not lost.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ps2_received_data  input  8  scan-code byte from ps2_controller.
- ps2_received_data_strb  input  1  one-cycle strobe; byte valid.
- key_code  output  8  make code at FIFO head.
- key_ext  output  1  head entry was E0-prefixed.
- key_valid  output  1  FIFO non-empty.
- key_ready  input  1  consumer accepts head this cycle.
- fifo_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- fifo_overflow  output  1  one-cycle pulse: a make code was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): parser state S_IDLE, pointers 0, fifo_count=0, key_valid=0, key_code=8'h00, key_ext=0, fifo_overflow=0.
- Parser FSM advances only on cycles with strb=1; bytes are sampled on that clk edge.
- S_IDLE:
  - 8'hF0 -> S_BREAK.
  - 8'hE0 -> S_EXT.
  - 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE -> dropped; stay in S_IDLE.
  - Any other byte -> push {ext=0, code}.
- S_BREAK: any byte -> discarded; -> S_IDLE.
- S_EXT:
  - 8'hF0 -> S_EXT_BREAK.
  - 8'hE0 -> stay in S_EXT.
  - Dropped-code set -> S_IDLE, no push.
  - Otherwise push {ext=1, code}; -> S_IDLE.
- S_EXT_BREAK: any byte -> discarded; -> S_IDLE.
- Push latency:
  - Entry written on the strobe edge.
  - key_valid/key_code/key_ext reflect it on the following cycle when the FIFO was empty (1-cycle latency).
- Show-ahead read:
  - key_code/key_ext are always the head entry while key_valid=1.
  - Pop happens on a clk edge with key_valid & key_ready.
  - key_ready while empty is ignored.
- When empty, key_code/key_ext hold the last popped values (0 after reset).
- Full (fifo_count==DEPTH):
  - Push without a same-cycle pop -> entry dropped, fifo_overflow pulses 1 cycle, pointers unchanged.
  - Push with a same-cycle pop -> both happen; count stays DEPTH; no overflow.
- Simultaneous push and pop on a non-empty, non-full FIFO -> count unchanged.
- Empty plus push: pop is not possible the same cycle; the new entry appears next cycle.
- Pointers wrap modulo DEPTH. Count is a separate PTR_W+1 register, so there is no full/empty ambiguity.
- Reset asserted mid-operation: FIFO is flushed and the FSM returns to S_IDLE. A partially received break sequence is forgotten, so the next byte is treated as fresh.
- ps2_controller guarantees ≥ thousands of cycles between strobes; back-to-back strobes must still be handled correctly, one byte per cycle.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- When defined:
  - Keeps a held-key register {valid, ext, code}.
  - A make code equal to the held key is dropped (typematic repeat), with no push and no overflow.
  - A different make code is pushed and replaces the held key.
  - A break for the held key (same ext/code) clears it.
  - A break for another key leaves it.
  - Reset clears it.
- When undefined: every make code is pushed, including repeats, and the held-key register is absent.

Test Plan:
- Reset, then bytes 1C, 29, 32 with key_ready=0 -> fifo_count=3; head key_code=8'h1C, key_ext=0; key_valid high 1 cycle after the first strobe.
- Bytes 1C, F0, 1C, 21 with key_ready=1 -> consumer sees exactly 1C then 21; F0 and the following 1C are never pushed.
- Bytes E0, 75, E0, F0, 75, 5A -> pops {ext=1, 75} then {ext=0, 5A}; fifo_count returns to 0.
- DEPTH=8, key_ready=0, 9 make codes -> count=8; overflow pulses once on the 9th; ninth code absent. Then the 10th strobe with key_ready=1 on the same cycle -> accepted, count stays 8.
- Three 1C strobes, no break, with PS2_TYPEMATIC_FILTER_EN defined -> one entry. Without the macro -> three entries. With the macro: F0 1C then 1C -> second entry pushed.
- Assert rst low after E0 F0 with 3 entries queued -> key_valid=0 and count=0 immediately (async). After release, byte 1C is pushed as a make code, not consumed as a break.
